register_fifo: RTL



---
 rtl/register_fifo_if.sv | 35 +++
 rtl/register_fifo.sv | 84 ++++++++
 2 files changed

// File: rtl/register_fifo_if.sv
// Producer/consumer side bundle of the register FIFO.
// Handshake: a write is taken on a rising edge where wr_en=1 and the FIFO
// has room (full=0, or a read is taken on the same edge); a read is taken
// on a rising edge where r_en=1 and empty=0. A taken read presents its word
// on out with out_valid=1 for the following cycle. Refused requests
// produce a one-cycle overflow or underflow pulse instead.
interface register_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_en;
    logic              r_en;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  out;
    logic              out_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    // Producer/consumer side: drives requests, observes data and status.
    modport master (
        output wr_en, r_en, data_in,
        input  out, out_valid, full, empty, count, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  wr_en, r_en, data_in,
        output out, out_valid, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/register_fifo.sv
// DEPTH-entry, WIDTH-bit synchronous FIFO built from a register array.
// Registered read data with a valid strobe, occupancy count, full/empty
// status and one-cycle overflow/underflow pulses. All outputs come from
// registers, so there is no combinational path from inputs to outputs.
module register_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    register_fifo_if.slave bus
);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [WIDTH-1:0]  r_out;
    logic              r_out_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;

    assign w_full  = (r_count == CNT_DEPTH);
    assign w_empty = (r_count == '0);

    // A read needs data present; a write needs room, which a same-edge
    // read provides even when full. On empty the read is refused, so no
    // read-through bypass exists.
    assign w_rd_acc = bus.r_en && !w_empty;
    assign w_wr_acc = bus.wr_en && (!w_full || w_rd_acc);

    // Storage array: no reset, contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    // Pointers, occupancy, read data and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_out    <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_out_valid <= w_rd_acc;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_overflow  <= bus.wr_en && w_full && !w_rd_acc;
            r_underflow <= bus.r_en && w_empty;
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule
